// File: rtl/button_bank.sv
// rtl/button_bank.sv - N-channel button debouncer with press/release, long-press and auto-repeat pulses
//
// Optional feature macro: BUTTON_BANK_REPEAT_EN (builds the auto-repeat logic in the LONG state).
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn            raw button pins (INV_MASK bit set = pin is active-low)
//   level          debounced active-high button state
//   press          one-clock pulse when level rises
//   release_pulse  one-clock pulse when level falls
//   long_press     one-clock pulse after a press has been held LONG_PRESS_CYCLES
//   repeat_pulse   one-clock auto-repeat pulse while held past the long press
//   any_press      OR of press, same cycle as press
// release/repeat are reserved words, hence the _pulse suffix on those two ports.

module button_bank #(
    parameter int               N_BTN             = 4,
    parameter int               DEBOUNCE_CYCLES   = 16,
    parameter int               LONG_PRESS_CYCLES = 1000,
    parameter int               REPEAT_CYCLES     = 200,
    parameter logic [N_BTN-1:0] INV_MASK          = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_press
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    // Compare against N-1 so the event is registered on the clock the count reaches N.
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LP_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT   = '1;

    typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_t;

    logic [N_BTN-1:0] sync1, sync2;
    logic [N_BTN-1:0] press_ev, release_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn ^ INV_MASK;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_ev;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          lvl_q, press_q, rel_q;
        logic          changed, db_done;

        assign changed       = sync2[i] ^ lvl_q;
        assign db_done       = changed && (db_cnt == DB_LAST);
        assign press_ev[i]   = db_done && !lvl_q;
        assign release_ev[i] = db_done && lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt  <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= press_ev[i];
                rel_q   <= release_ev[i];
                if (!changed) begin
                    db_cnt <= '0;
                end else if (db_done) begin
                    db_cnt <= '0;
                    lvl_q  <= ~lvl_q;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        hold_state_t st, st_nx;
        logic [HW-1:0] hcnt, hcnt_nx, hcnt_inc;
        logic          lp_nx, lp_q;

        assign hcnt_inc = (hcnt == H_SAT) ? hcnt : hcnt + 1'b1;

`ifdef BUTTON_BANK_REPEAT_EN
        localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_CYCLES - 1);
        logic rp_nx, rp_q;
`endif

        always_comb begin
            st_nx   = st;
            hcnt_nx = hcnt;
            lp_nx   = 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
            rp_nx   = 1'b0;
`endif
            // Release wins over any long-press/repeat due on the same clock.
            if (release_ev[i]) begin
                st_nx   = IDLE;
                hcnt_nx = '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (press_ev[i]) begin
                            st_nx   = HELD;
                            hcnt_nx = '0;
                        end
                    end
                    HELD: begin
                        if (hcnt == LP_LAST) begin
                            lp_nx   = 1'b1;
                            st_nx   = LONG;
                            hcnt_nx = '0;
                        end else begin
                            hcnt_nx = hcnt_inc;
                        end
                    end
                    LONG: begin
`ifdef BUTTON_BANK_REPEAT_EN
                        if (hcnt == RP_LAST) begin
                            rp_nx   = 1'b1;
                            hcnt_nx = '0;
                        end else begin
                            hcnt_nx = hcnt_inc;
                        end
`else
                        st_nx = LONG;
`endif
                    end
                    default: st_nx = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st   <= IDLE;
                hcnt <= '0;
                lp_q <= 1'b0;
            end else begin
                st   <= st_nx;
                hcnt <= hcnt_nx;
                lp_q <= lp_nx;
            end
        end

`ifdef BUTTON_BANK_REPEAT_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rp_q <= 1'b0;
            end else begin
                rp_q <= rp_nx;
            end
        end
        assign repeat_pulse[i] = rp_q;
`else
        assign repeat_pulse[i] = 1'b0;
`endif

        assign level[i]         = lvl_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
        assign long_press[i]    = lp_q;
    end

endmodule
